// File: rtl/ap_cam_array_pkg.sv
// ap_pkg: opcode encoding shared by the AP CAM array and its users.
package ap_pkg;
    typedef logic [2:0] ap_op_t;
    localparam ap_op_t AP_NOP     = 3'd0;
    localparam ap_op_t AP_WR_ROW  = 3'd1;
    localparam ap_op_t AP_WR_COL  = 3'd2;
    localparam ap_op_t AP_RD_ROW  = 3'd3;
    localparam ap_op_t AP_RD_COL  = 3'd4;
    localparam ap_op_t AP_COMPARE = 3'd5;
    localparam ap_op_t AP_WR_TAG  = 3'd6;
    localparam ap_op_t AP_LOAD    = 3'd7;
endpackage

// File: rtl/ap_cam_array_prio_enc.sv
// ap_prio_enc: lowest set index of a vector plus an any-bit-set flag.
module ap_prio_enc #(
    parameter int DATA_DEPTH     = 16,
    parameter int ADDR_WIDTH_CAM = 8
) (
    input  logic [DATA_DEPTH-1:0]     vec,
    output logic [ADDR_WIDTH_CAM-1:0] idx,
    output logic                      any
);
    always_comb begin
        idx = '0;
        for (int i = DATA_DEPTH - 1; i >= 0; i--)
            if (vec[i]) idx = ADDR_WIDTH_CAM'(i);
        any = |vec;
    end
endmodule

// File: rtl/ap_cam_array.sv
// ap_cam_array: associative-processor CAM bit matrix with per-row tags,
// one command per cycle behind a single-entry registered response.
module ap_cam_array
    import ap_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int DATA_DEPTH     = 16,
    parameter int ADDR_WIDTH_CAM = 8
) (
    input  logic                             clk,
    input  logic                             rstIn,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  ap_op_t                           cmd_op,
    input  logic                             cmd_acc,
    input  logic [ADDR_WIDTH_CAM-1:0]        cmd_addr,
    input  logic [DATA_WIDTH-1:0]            cmd_row,
    input  logic [DATA_DEPTH-1:0]            cmd_col,
    input  logic [DATA_WIDTH-1:0]            key,
    input  logic [DATA_WIDTH-1:0]            mask,
    input  logic [DATA_WIDTH*DATA_DEPTH-1:0] load_bus,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_row,
    output logic [DATA_DEPTH-1:0]            rsp_col,
    output logic                             rsp_hit,
    output logic [ADDR_WIDTH_CAM-1:0]        rsp_first,
    output logic                             rsp_err,
    output logic [DATA_DEPTH-1:0]            tag_row,
    output logic [DATA_WIDTH*DATA_DEPTH-1:0] array_q
);
    localparam logic [ADDR_WIDTH_CAM:0] DEPTH_X = (ADDR_WIDTH_CAM+1)'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH_CAM:0] WIDTH_X = (ADDR_WIDTH_CAM+1)'(DATA_WIDTH);

    logic [DATA_WIDTH*DATA_DEPTH-1:0] array_d;
    logic [DATA_DEPTH-1:0]            tag_q, tag_d, match, cmp_tag, rd_col;
    logic [DATA_WIDTH-1:0]            rd_row;
    logic                             rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d, rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]            rsp_row_q, rsp_row_d;
    logic [DATA_DEPTH-1:0]            rsp_col_q, rsp_col_d;
    logic [ADDR_WIDTH_CAM-1:0]        rsp_first_q, rsp_first_d, first_idx;
    logic                             any_hit, accept, row_ok, col_ok;

    assign cmd_ready = ~rsp_valid_q | rsp_ready;
    assign accept    = cmd_valid & cmd_ready;
    assign row_ok    = {1'b0, cmd_addr} < DEPTH_X;
    assign col_ok    = {1'b0, cmd_addr} < WIDTH_X;

    always_comb begin
        match  = '0;
        rd_row = '0;
        rd_col = '0;
        for (int i = 0; i < DATA_DEPTH; i++) begin
            match[i] = &(~(array_q[i*DATA_WIDTH +: DATA_WIDTH] ^ key) | ~mask);
            if (cmd_addr == ADDR_WIDTH_CAM'(i)) rd_row = array_q[i*DATA_WIDTH +: DATA_WIDTH];
            for (int j = 0; j < DATA_WIDTH; j++)
                if (cmd_addr == ADDR_WIDTH_CAM'(j)) rd_col[i] = array_q[i*DATA_WIDTH + j];
        end
        cmp_tag = cmd_acc ? tag_q & match : match;
    end

    ap_prio_enc #(
        .DATA_DEPTH    (DATA_DEPTH),
        .ADDR_WIDTH_CAM(ADDR_WIDTH_CAM)
    ) u_prio (
        .vec(cmp_tag),
        .idx(first_idx),
        .any(any_hit)
    );

    always_comb begin
        array_d     = array_q;
        tag_d       = tag_q;
        rsp_valid_d = rsp_valid_q & ~rsp_ready;
        rsp_row_d   = rsp_row_q;
        rsp_col_d   = rsp_col_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_first_d = rsp_first_q;
        rsp_err_d   = rsp_err_q;
        if (accept && cmd_op != AP_NOP) begin
            rsp_valid_d = 1'b1;
            rsp_row_d   = '0;
            rsp_col_d   = '0;
            rsp_hit_d   = 1'b0;
            rsp_first_d = '0;
            rsp_err_d   = ((cmd_op == AP_WR_ROW || cmd_op == AP_RD_ROW) && !row_ok) ||
                          ((cmd_op == AP_WR_COL || cmd_op == AP_RD_COL) && !col_ok);
            case (cmd_op)
                AP_WR_ROW:
                    for (int i = 0; i < DATA_DEPTH; i++)
                        if (cmd_addr == ADDR_WIDTH_CAM'(i)) array_d[i*DATA_WIDTH +: DATA_WIDTH] = cmd_row;
                AP_WR_COL:
                    for (int i = 0; i < DATA_DEPTH; i++)
                        for (int j = 0; j < DATA_WIDTH; j++)
                            if (cmd_addr == ADDR_WIDTH_CAM'(j)) array_d[i*DATA_WIDTH + j] = cmd_col[i];
                AP_RD_ROW: rsp_row_d = row_ok ? rd_row : '0;
                AP_RD_COL: rsp_col_d = col_ok ? rd_col : '0;
                AP_COMPARE: begin
                    tag_d       = cmp_tag;
                    rsp_col_d   = cmp_tag;
                    rsp_hit_d   = any_hit;
                    rsp_first_d = first_idx;
                end
                AP_WR_TAG:
                    for (int i = 0; i < DATA_DEPTH; i++)
                        if (tag_q[i])
                            array_d[i*DATA_WIDTH +: DATA_WIDTH] =
                                (array_q[i*DATA_WIDTH +: DATA_WIDTH] & ~mask) | (key & mask);
                AP_LOAD: begin
                    array_d = load_bus;
                    tag_d   = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstIn) begin
            array_q     <= '0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_row_q   <= '0;
            rsp_col_q   <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_first_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            array_q     <= array_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_row_q   <= rsp_row_d;
            rsp_col_q   <= rsp_col_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_first_q <= rsp_first_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_row   = rsp_row_q;
    assign rsp_col   = rsp_col_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_first = rsp_first_q;
    assign rsp_err   = rsp_err_q;
    assign tag_row   = tag_q;
endmodule

// File: tb/tb_ap_cam_array.sv
// tb_ap_cam_array: directed plus random commands checked against a row-array
// reference model of the CAM, including backpressure and reset-mid-stall.
module tb_ap_cam_array;
    import ap_pkg::*;

    logic         clk = 1'b0;
    logic         rstIn, cmd_valid, cmd_ready, cmd_acc, rsp_valid, rsp_ready, rsp_hit, rsp_err;
    ap_op_t       cmd_op;
    logic [7:0]   cmd_addr, cmd_row, key, mask, rsp_row, rsp_first;
    logic [15:0]  cmd_col, rsp_col, tag_row;
    logic [127:0] load_bus, array_q;

    ap_cam_array dut (
        .clk(clk), .rstIn(rstIn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_acc(cmd_acc), .cmd_addr(cmd_addr), .cmd_row(cmd_row),
        .cmd_col(cmd_col), .key(key), .mask(mask), .load_bus(load_bus),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_row(rsp_row), .rsp_col(rsp_col),
        .rsp_hit(rsp_hit), .rsp_first(rsp_first), .rsp_err(rsp_err),
        .tag_row(tag_row), .array_q(array_q)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_err = 0;
    logic [7:0]  mem [16];
    logic [15:0] mtag;
    logic [7:0]  e_row, e_first;
    logic [15:0] e_col;
    logic        e_hit, e_err;

    task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    function automatic logic [127:0] mpack();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = mem[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mtag = '0;
    endtask

    task automatic model(input ap_op_t op, input logic acc, input int addr, input logic [7:0] row,
                         input logic [15:0] col, input logic [7:0] k, input logic [7:0] m,
                         input logic [127:0] ld);
        logic [15:0] hits;
        e_row = 0; e_col = 0; e_hit = 0; e_first = 0; e_err = 0;
        case (op)
            AP_WR_ROW: if (addr < 16) mem[addr] = row; else e_err = 1;
            AP_WR_COL: if (addr < 8) for (int i = 0; i < 16; i++) mem[i][addr] = col[i]; else e_err = 1;
            AP_RD_ROW: if (addr < 16) e_row = mem[addr]; else e_err = 1;
            AP_RD_COL: if (addr < 8) for (int i = 0; i < 16; i++) e_col[i] = mem[i][addr]; else e_err = 1;
            AP_COMPARE: begin
                for (int i = 0; i < 16; i++) hits[i] = (mem[i] & m) == (k & m);
                mtag  = acc ? (mtag & hits) : hits;
                e_col = mtag;
                e_hit = mtag != 0;
                for (int i = 15; i >= 0; i--) if (mtag[i]) e_first = 8'(i);
            end
            AP_WR_TAG: for (int i = 0; i < 16; i++) if (mtag[i]) mem[i] = (mem[i] & ~m) | (k & m);
            AP_LOAD: begin
                for (int i = 0; i < 16; i++) mem[i] = ld[i*8 +: 8];
                mtag = '0;
            end
            default: ;
        endcase
    endtask

    task automatic do_cmd(input ap_op_t op, input logic acc, input logic [7:0] addr, input logic [7:0] row,
                          input logic [15:0] col, input logic [7:0] k, input logic [7:0] m,
                          input logic [127:0] ld);
        cmd_op = op; cmd_acc = acc; cmd_addr = addr; cmd_row = row; cmd_col = col;
        key = k; mask = m; load_bus = ld; cmd_valid = 1'b1;
        chk("cmd_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        model(op, acc, int'(addr), row, col, k, m, ld);
        chk("rsp_valid", rsp_valid, op != AP_NOP);
        if (op != AP_NOP) begin
            chk("rsp_row", rsp_row, e_row);
            chk("rsp_col", rsp_col, e_col);
            chk("rsp_hit", rsp_hit, e_hit);
            chk("rsp_first", rsp_first, e_first);
            chk("rsp_err", rsp_err, e_err);
        end
        chk("tag_row", tag_row, mtag);
        chk("array_q", array_q, mpack());
    endtask

    initial begin
        logic [127:0] ld;
        logic [7:0]   held_row;
        rstIn = 1'b1; rsp_ready = 1'b1; cmd_acc = 0; cmd_col = 0; key = 0; mask = 0; load_bus = 0;
        cmd_valid = 1'b1; cmd_op = AP_WR_ROW; cmd_addr = 8'd0; cmd_row = 8'hFF;
        model_reset();
        repeat (2) @(posedge clk);
        #1 cmd_valid = 1'b0; rstIn = 1'b0;
        chk("reset_valid", rsp_valid, 1'b0);
        chk("reset_array", array_q, 128'h0);
        chk("reset_tag", tag_row, 16'h0);
        chk("reset_row", rsp_row, 8'h0);

        do_cmd(AP_RD_ROW, 0, 8'd3, 0, 0, 0, 0, 0);
        chk("rd3_row_const", rsp_row, 8'h00);
        do_cmd(AP_NOP, 0, 0, 0, 0, 0, 0, 0);

        do_cmd(AP_WR_ROW, 0, 8'd5, 8'hA5, 0, 0, 0, 0);
        do_cmd(AP_RD_COL, 0, 8'd0, 0, 0, 0, 0, 0);
        chk("rdcol0_const", rsp_col, 16'h0020);
        do_cmd(AP_RD_COL, 0, 8'd1, 0, 0, 0, 0, 0);
        chk("rdcol1_const", rsp_col, 16'h0000);

        for (int i = 0; i < 16; i++) ld[i*8 +: 8] = 8'(i);
        do_cmd(AP_LOAD, 0, 0, 0, 0, 0, 0, ld);
        do_cmd(AP_COMPARE, 0, 0, 0, 0, 8'h04, 8'h0C, 0);
        chk("cmp1_tag_const", rsp_col, 16'h00F0);
        chk("cmp1_first_const", rsp_first, 8'd4);
        do_cmd(AP_COMPARE, 1, 0, 0, 0, 8'h01, 8'h01, 0);
        chk("cmp2_tag_const", rsp_col, 16'h00A0);
        chk("cmp2_first_const", rsp_first, 8'd5);
        do_cmd(AP_WR_TAG, 0, 0, 0, 0, 8'hF0, 8'hF0, 0);
        chk("wrtag_r5", array_q[5*8 +: 8], 8'hF5);
        chk("wrtag_r7", array_q[7*8 +: 8], 8'hF7);
        chk("wrtag_r4", array_q[4*8 +: 8], 8'h04);
        do_cmd(AP_WR_TAG, 0, 0, 0, 0, 8'h00, 8'h00, 0);
        do_cmd(AP_COMPARE, 0, 0, 0, 0, 8'h5A, 8'h00, 0);
        chk("mask0_all", rsp_col, 16'hFFFF);
        do_cmd(AP_COMPARE, 0, 0, 0, 0, 8'hEE, 8'hFF, 0);
        chk("nohit_first", rsp_first, 8'd0);
        do_cmd(AP_WR_TAG, 0, 0, 0, 0, 8'hFF, 8'hFF, 0);

        do_cmd(AP_WR_ROW, 0, 8'd16, 8'h33, 0, 0, 0, 0);
        chk("wr16_err_const", rsp_err, 1'b1);
        do_cmd(AP_WR_COL, 0, 8'd8, 0, 16'hFFFF, 0, 0, 0);
        do_cmd(AP_WR_COL, 0, 8'd7, 0, 16'h8001, 0, 0, 0);
        do_cmd(AP_RD_COL, 0, 8'd9, 0, 0, 0, 0, 0);
        do_cmd(AP_RD_ROW, 0, 8'd255, 0, 0, 0, 0, 0);

        for (int n = 0; n < 300; n++)
            do_cmd(ap_op_t'($urandom_range(0, 7)), 1'($urandom), 8'($urandom_range(0, 17)),
                   8'($urandom), 16'($urandom), 8'($urandom), 8'($urandom & $urandom),
                   {$urandom, $urandom, $urandom, $urandom});

        do_cmd(AP_NOP, 0, 0, 0, 0, 0, 0, 0);
        rsp_ready = 1'b0;
        do_cmd(AP_RD_ROW, 0, 8'd2, 0, 0, 0, 0, 0);
        held_row = e_row;
        cmd_op = AP_WR_ROW; cmd_addr = 8'd2; cmd_row = ~held_row; cmd_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("stall_ready", cmd_ready, 1'b0);
            chk("stall_valid", rsp_valid, 1'b1);
            chk("stall_row", rsp_row, held_row);
            chk("stall_array", array_q, mpack());
        end
        rstIn = 1'b1;
        @(posedge clk);
        #1 rstIn = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        model_reset();
        chk("rst_stall_valid", rsp_valid, 1'b0);
        chk("rst_stall_array", array_q, 128'h0);
        chk("rst_stall_tag", tag_row, 16'h0);
        do_cmd(AP_RD_ROW, 0, 8'd2, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ap_cam_array.md
# ap_cam_array

Parametrised associative-processor CAM array, successor to the single-cycle bit-cell array. It holds a DATA_DEPTH × DATA_WIDTH bit matrix and a per-row tag register, and executes one command per cycle: row/column read and write, masked key compare with optional tag accumulation, masked tagged write, and bulk load. Commands and responses use valid/ready handshakes, so it sits directly behind the AP controller FSM and needs no external glue.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per row (columns)
- DATA_DEPTH, 16, number of rows
- ADDR_WIDTH_CAM, 8, command address width; must satisfy 2^ADDR_WIDTH_CAM ≥ max(DATA_WIDTH, DATA_DEPTH)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rstIn  in  1  synchronous reset, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  3  opcode (see Operation)
- cmd_acc  in  1  COMPARE only: AND the result into the existing tags
- cmd_addr  in  ADDR_WIDTH_CAM  row index (row ops) or column index (column ops)
- cmd_row  in  DATA_WIDTH  row write data
- cmd_col  in  DATA_DEPTH  column write data
- key  in  DATA_WIDTH  compare / tagged-write value
- mask  in  DATA_WIDTH  1 = bit participates
- load_bus  in  DATA_WIDTH*DATA_DEPTH  bulk-load image; row i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_row  out  DATA_WIDTH  RD_ROW data
- rsp_col  out  DATA_DEPTH  RD_COL data, or the new tag vector after COMPARE
- rsp_hit  out  1  COMPARE: at least one tag set
- rsp_first  out  ADDR_WIDTH_CAM  COMPARE: lowest tagged row index (0 when no hit)
- rsp_err  out  1  address out of range; no state changed
- tag_row  out  DATA_DEPTH  live tag register
- array_q  out  DATA_WIDTH*DATA_DEPTH  live array contents, same packing as load_bus

## Operation
Opcodes:
- 0 NOP: no effect, no response.
- 1 WR_ROW: row[addr] ← cmd_row.
- 2 WR_COL: bit addr of every row i ← cmd_col[i].
- 3 RD_ROW: rsp_row ← row[addr].
- 4 RD_COL: rsp_col[i] ← row[i][addr].
- 5 COMPARE: match[i] = &(~(row[i] ^ key) | ~mask). tag ← cmd_acc ? tag & match : match. rsp_col, rsp_hit and rsp_first reflect the new tag value.
- 6 WR_TAG: for every row with tag[i]=1, bits where mask=1 ← key; all other bits are unchanged. Tags are unchanged.
- 7 LOAD: array ← load_bus. Tags are cleared.

Address checks:
- Row ops (1, 3) require addr < DATA_DEPTH; column ops (2, 4) require addr < DATA_WIDTH.
- On violation: no array or tag change, response issued with rsp_err=1 and data fields 0.

Responses:
- Every accepted non-NOP command produces exactly one response.
- Writes return an ack response with all data fields 0.
- Fields not relevant to the opcode are 0.

Edge cases:
- mask = 0 → COMPARE tags every row (acc=0); WR_TAG is a no-op.
- Empty tag vector → WR_TAG changes nothing, response still issued.

## Timing
- Reset values: array all 0, tag 0, rsp_valid 0, all rsp_* 0. A pending response is dropped.
- cmd_ready = ~rsp_valid | rsp_ready (combinational; single-entry output register).
- Command accepted at edge T → array, tag and response register update at T; rsp_valid=1 in the cycle after T.
- Throughput is one command per cycle while rsp_ready=1.
- Back-to-back WR_ROW then RD_ROW of the same row returns the new data. COMPARE followed immediately by WR_TAG uses the new tags.
- If rsp_valid & ~rsp_ready: cmd_ready=0, and the response fields hold stable until consumed.
- rsp_valid falls on the edge where rsp_ready=1 and no new command is accepted.
- tag_row and array_q reflect register state (no combinational path from inputs).
- cmd_valid during rstIn=1 is ignored.

## Structure
- Package ap_pkg holds:
  - opcode localparams: AP_NOP, AP_WR_ROW, AP_WR_COL, AP_RD_ROW, AP_RD_COL, AP_COMPARE, AP_WR_TAG, AP_LOAD
  - typedef ap_op_t (3 bits)
- Sub-module ap_prio_enc (parametrised DATA_DEPTH → ADDR_WIDTH_CAM) produces the lowest set index plus an any-flag from the next tag value. It is used for rsp_first and rsp_hit.
- Array is a flat register vector with a single clocked update process, plus a combinational next-state and match block.

## Test plan
- Reset, then RD_ROW addr 3 → rsp_row=0x00, rsp_err=0, one response only.
- WR_ROW r5=0xA5, then RD_COL c0 → rsp_col=0x0020; RD_COL c1 → 0x0000.
- LOAD rows i=i; COMPARE key=0x04 mask=0x0C acc=0 → tags rows {4,5,6,7} = 0x00F0, rsp_hit=1, rsp_first=4. Then COMPARE key=0x01 mask=0x01 acc=1 → tags 0x00A0, rsp_first=5.
- With tags 0x00A0: WR_TAG key=0xF0 mask=0xF0 → row5=0xF5, row7=0xF7, row4=0x04 unchanged.
- WR_ROW addr=16 (DATA_DEPTH=16) → rsp_err=1, array unchanged. WR_COL addr=8 → rsp_err=1.
- Hold rsp_ready=0 for 3 cycles after RD_ROW → cmd_ready=0 and rsp fields stable. Assert rstIn mid-stall → rsp_valid=0 next cycle and array cleared.
